fetch_stage: RTL and testbench

//   IF stage plus IF/ID pipeline register of the LoongArch32 pipeline. Holds the PC and

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC generation, synchronous ROM addressing,
// load-use hold, EX redirect squash and a stall-cycle performance counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] NOP_INST = 32'h03400000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_from_Load,
    input  logic             jump_EX,
    input  logic [31:0]      jump_target_EX,
    output logic [31:0]      irom_addr,
    input  logic [31:0]      irom_rdata,
    output logic [31:0]      pc_ID,
    output logic [31:0]      inst_ID,
    output logic             valid_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             fsm_state
);

    // valid_ID qualifies {pc_ID, inst_ID}; there is no ready, the ID side
    // back-pressures only through stall_from_Load, which freezes IF and IF/ID.
    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc_if;
    logic [31:0] npc;
    logic        hold;

    assign fsm_state = state;
    assign irom_addr = npc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // In BOOT the ROM output is stale, so npc re-requests pc_if to establish
    // the rdata-matches-pc_if invariant before RUN.
    always_comb begin
        next_state = RUN;
        hold       = 1'b0;
        npc        = pc_if + 32'd4;
        if (!rstn) begin
            next_state = BOOT;
            npc        = RESET_PC;
        end else if (jump_EX) begin
            npc = {jump_target_EX[31:2], 2'b00};
        end else if (state == BOOT) begin
            npc = pc_if;
        end else if (stall_from_Load) begin
            hold = 1'b1;
            npc  = pc_if;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_if     <= RESET_PC;
            pc_ID     <= 32'd0;
            inst_ID   <= NOP_INST;
            valid_ID  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pc_if <= npc;
            if (state == BOOT || jump_EX) begin
                pc_ID    <= pc_if;
                inst_ID  <= NOP_INST;
                valid_ID <= 1'b0;
            end else if (!hold) begin
                pc_ID    <= pc_if;
                inst_ID  <= irom_rdata;
                valid_ID <= 1'b1;
            end
            if (hold) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected ID-stage
// instructions, drained by a monitor, plus direct checks of address and bubbles.
module tb_fetch_stage;

    localparam logic [31:0] R    = 32'h1c000000;
    localparam logic [31:0] NOP  = 32'h03400000;
    localparam logic [31:0] SALT = 32'h0F0F0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, stall, jump;
    logic [31:0] target, irom_addr, irom_rdata, pc_ID, inst_ID;
    logic        valid_ID, fsm_state;
    logic [31:0] stall_cnt;

    logic        rstn2, stall2, jump2;
    logic [31:0] target2, irom_addr2, irom_rdata2, pc_ID2, inst_ID2;
    logic        valid_ID2, fsm_state2;
    logic [3:0]  stall_cnt2;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic        in_run = 1'b0;
    logic        held_last = 1'b0;

    fetch_stage dut (
        .clk(clk), .rstn(rstn), .stall_from_Load(stall), .jump_EX(jump),
        .jump_target_EX(target), .irom_addr(irom_addr), .irom_rdata(irom_rdata),
        .pc_ID(pc_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
        .stall_cnt(stall_cnt), .fsm_state(fsm_state)
    );

    fetch_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn2), .stall_from_Load(stall2), .jump_EX(jump2),
        .jump_target_EX(target2), .irom_addr(irom_addr2), .irom_rdata(irom_rdata2),
        .pc_ID(pc_ID2), .inst_ID(inst_ID2), .valid_ID(valid_ID2),
        .stall_cnt(stall_cnt2), .fsm_state(fsm_state2)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    always @(posedge clk) begin
        irom_rdata  <= rom_word(irom_addr);
        irom_rdata2 <= rom_word(irom_addr2);
        held_last   <= rstn && in_run && stall && !jump;
        in_run      <= rstn;
    end

    // Monitor: every newly loaded real instruction must be the next one expected.
    always @(negedge clk) begin
        if (rstn && valid_ID && !held_last) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL id_unexpected: got pc_ID=%h inst_ID=%h, required none", pc_ID, inst_ID);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc_ID !== e || inst_ID !== rom_word(e)) begin
                    fails++;
                    $display("FAIL id_stream: got pc_ID=%h inst_ID=%h, required pc_ID=%h inst_ID=%h",
                             pc_ID, inst_ID, e, rom_word(e));
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic s, input logic j, input logic [31:0] t);
        stall  = s;
        jump   = j;
        target = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; drive(1'b0, 1'b0, 32'd0);
        rstn2 = 1'b0; stall2 = 1'b0; jump2 = 1'b0; target2 = 32'd0;
        repeat (2) tick();
        check("rst_addr", irom_addr, R);
        check("rst_valid", {31'd0, valid_ID}, 32'd0);
        check("rst_inst", inst_ID, NOP);
        check("rst_pc", pc_ID, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_state", {31'd0, fsm_state}, 32'd0);

        // Boot, then straight-line fetch
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(R + 32'(4 * i));
        #1 check("boot_addr", irom_addr, R);
        tick();
        check("boot_bubble_valid", {31'd0, valid_ID}, 32'd0);
        check("boot_bubble_inst", inst_ID, NOP);
        check("run_state", {31'd0, fsm_state}, 32'd1);
        repeat (4) tick();

        // Three-cycle load-use stall at pc_IF = R+0x10
        drive(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_addr", irom_addr, R + 32'h10);
            tick();
            check("stall_pc_frozen", pc_ID, R + 32'h0c);
            check("stall_inst_frozen", inst_ID, rom_word(R + 32'h0c));
        end
        check("stall_cnt_3", stall_cnt, 32'd3);
        drive(1'b0, 1'b0, 32'd0);
        repeat (2) tick();

        // Redirect with misaligned target
        exp_q.push_back(32'h1c000100);
        exp_q.push_back(32'h1c000104);
        drive(1'b0, 1'b1, 32'h1c000103);
        #1 check("jump_addr", irom_addr, 32'h1c000100);
        tick();
        check("squash_valid", {31'd0, valid_ID}, 32'd0);
        check("squash_inst", inst_ID, NOP);
        drive(1'b0, 1'b0, 32'd0);
        repeat (2) tick();

        // Jump and stall together: jump wins, no count
        exp_q.push_back(32'h1c000200);
        drive(1'b1, 1'b1, 32'h1c000200);
        #1 check("jump_stall_addr", irom_addr, 32'h1c000200);
        tick();
        check("jump_stall_valid", {31'd0, valid_ID}, 32'd0);
        check("jump_stall_cnt", stall_cnt, 32'd3);
        drive(1'b0, 1'b0, 32'd0);
        tick();

        // PC wrap at the top of the address space
        exp_q.push_back(32'hFFFFFFFC);
        drive(1'b0, 1'b1, 32'hFFFFFFFF);
        #1 check("top_addr", irom_addr, 32'hFFFFFFFC);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        #1 check("wrap_addr", irom_addr, 32'h00000000);
        tick();

        // Reset in the middle of a stall at pc_IF = R+0x40
        drive(1'b0, 1'b1, R + 32'h40);
        tick();
        drive(1'b1, 1'b0, 32'd0);
        #1 check("stall40_addr", irom_addr, R + 32'h40);
        tick();
        check("stall40_cnt", stall_cnt, 32'd4);
        rstn = 1'b0;
        #1 check("rst_mid_addr", irom_addr, R);
        tick();
        check("rst_mid_state", {31'd0, fsm_state}, 32'd0);
        check("rst_mid_valid", {31'd0, valid_ID}, 32'd0);
        check("rst_mid_cnt", stall_cnt, 32'd0);
        check("rst_mid_inst", inst_ID, NOP);

        // Stall during BOOT is ignored
        rstn = 1'b1;
        exp_q.push_back(R);
        exp_q.push_back(R + 32'h4);
        #1 check("reboot_addr", irom_addr, R);
        tick();
        check("boot_stall_cnt", stall_cnt, 32'd0);
        check("reboot_valid", {31'd0, valid_ID}, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        drive(1'b1, 1'b0, 32'd0);

        // Counter wrap on the 4-bit build
        rstn2 = 1'b1;
        stall2 = 1'b1;
        tick();
        check("cnt4_boot", {28'd0, stall_cnt2}, 32'd0);
        repeat (15) tick();
        check("cnt4_max", {28'd0, stall_cnt2}, 32'd15);
        tick();
        check("cnt4_wrap", {28'd0, stall_cnt2}, 32'd0);

        #5;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
